axis_stall_detector: RTL and testbench

- Per-channel AXI-Stream handshake watcher feeding the `axis_block_sigs` vector of the dataflow deadlock monitor in the HLS cosim testbench.
- Each channel sits on one top-level AXIS port of the DUT. It flags a channel as blocked when the DUT has been waiting on that handshake for `STALL_CYCLES` consecutive cycles.
- Also captures which channel blocked first and the cycle at which it blocked, for the testbench deadlock report.

---
 rtl/axis_stall_detector.sv | 174 +++++++++++++++++
 tb/tb_axis_stall_detector.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/axis_stall_detector.sv
// Per-channel AXI-Stream stall watcher: flags channels stuck waiting on a handshake and records the first one.
// Optional per-channel blocked-cycle statistics are built when AXIS_STALL_STATS_EN is defined.
module axis_stall_detector #(
  parameter int                NUM_CH       = 2,
  parameter int                STALL_CYCLES = 16,
  parameter logic [NUM_CH-1:0] DIR_MASK     = NUM_CH'(2'b01),
  parameter int                CNT_W        = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic [NUM_CH-1:0] tvalid,
  input  logic [NUM_CH-1:0] tready,
  output logic [NUM_CH-1:0] axis_block_sigs,
  output logic              any_block,
  output logic [3:0]        first_ch,
  output logic              first_valid,
  output logic [31:0]       first_time,
  input  logic              clear,
  input  logic [3:0]        stat_sel,
  output logic [31:0]       stat_cycles
);

  localparam logic [CNT_W-1:0] STALL_MAX = CNT_W'(STALL_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_BLOCKED = 2'd2
  } ch_state_t;

  ch_state_t         state_q [NUM_CH];
  ch_state_t         state_d [NUM_CH];
  logic [CNT_W-1:0]  cnt_q   [NUM_CH];
  logic [CNT_W-1:0]  cnt_d   [NUM_CH];
  logic [NUM_CH-1:0] wait_w;
  logic [NUM_CH-1:0] block_d;
  logic [NUM_CH-1:0] enter_w;
  logic [NUM_CH-1:0] block_q;
  logic              any_q;
  logic [31:0]       cyc_q;
  logic              first_valid_q;
  logic [3:0]        first_ch_q;
  logic [31:0]       first_time_q;
  logic              hit;
  logic [3:0]        hit_idx;

  // Input channels stall when the DUT is ready but starved; output channels when backpressured.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      wait_w[i]  = DIR_MASK[i] ? (tready[i] & ~tvalid[i]) : (tvalid[i] & ~tready[i]);
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      if (clear || !enable) begin
        state_d[i] = S_IDLE;
        cnt_d[i]   = '0;
      end else begin
        case (state_q[i])
          S_IDLE: begin
            if (wait_w[i]) begin
              state_d[i] = S_WAIT;
              cnt_d[i]   = CNT_W'(1);
            end
          end
          S_WAIT: begin
            if (wait_w[i]) begin
              cnt_d[i] = cnt_q[i] + CNT_W'(1);
              if ((cnt_q[i] + CNT_W'(1)) == STALL_MAX) state_d[i] = S_BLOCKED;
            end else begin
              state_d[i] = S_IDLE;
              cnt_d[i]   = '0;
            end
          end
          S_BLOCKED: begin
            if (wait_w[i]) begin
              cnt_d[i] = STALL_MAX;
            end else begin
              state_d[i] = S_IDLE;
              cnt_d[i]   = '0;
            end
          end
          default: begin
            state_d[i] = S_IDLE;
            cnt_d[i]   = '0;
          end
        endcase
      end
      block_d[i] = (state_d[i] == S_BLOCKED);
      enter_w[i] = block_d[i] && (state_q[i] != S_BLOCKED);
    end

    hit     = 1'b0;
    hit_idx = 4'd0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (enter_w[i] && !hit) begin
        hit     = 1'b1;
        hit_idx = 4'(i);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= S_IDLE;
        cnt_q[i]   <= '0;
      end
      block_q       <= '0;
      any_q         <= 1'b0;
      cyc_q         <= '0;
      first_valid_q <= 1'b0;
      first_ch_q    <= '0;
      first_time_q  <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      block_q <= block_d;
      any_q   <= |block_d;
      cyc_q   <= cyc_q + 32'd1;
      if (clear) begin
        first_valid_q <= 1'b0;
        first_ch_q    <= '0;
        first_time_q  <= '0;
      end else if (!first_valid_q && hit) begin
        first_valid_q <= 1'b1;
        first_ch_q    <= hit_idx;
        first_time_q  <= cyc_q;
      end
    end
  end

  assign axis_block_sigs = block_q;
  assign any_block       = any_q;
  assign first_valid     = first_valid_q;
  assign first_ch        = first_ch_q;
  assign first_time      = first_time_q;

`ifdef AXIS_STALL_STATS_EN
  logic [31:0] stat_cnt_q [NUM_CH];
  logic [31:0] stat_mux;
  logic [31:0] stat_q;

  // Out-of-range selects match no channel and read as zero.
  always_comb begin
    stat_mux = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (stat_sel == 4'(i)) stat_mux = stat_cnt_q[i];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CH; i++) stat_cnt_q[i] <= '0;
      stat_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (clear) stat_cnt_q[i] <= '0;
        else if ((state_q[i] == S_BLOCKED) && (stat_cnt_q[i] != 32'hFFFF_FFFF))
          stat_cnt_q[i] <= stat_cnt_q[i] + 32'd1;
      end
      stat_q <= stat_mux;
    end
  end

  assign stat_cycles = stat_q;
`else
  logic unused_stat_sel;
  assign unused_stat_sel = ^stat_sel;
  assign stat_cycles     = '0;
`endif

endmodule

// File: tb/tb_axis_stall_detector.sv
// Directed bench for axis_stall_detector (NUM_CH=2, STALL_CYCLES=4, ch0 = DUT input, ch1 = DUT output).
// Stats expectations follow AXIS_STALL_STATS_EN when it is defined for the build.
module tb_axis_stall_detector;

`ifdef AXIS_STALL_STATS_EN
  localparam logic [31:0] EXP_STAT = 32'd10;
`else
  localparam logic [31:0] EXP_STAT = 32'd0;
`endif

  logic        clock;
  logic        reset;
  logic        enable;
  logic [1:0]  tvalid;
  logic [1:0]  tready;
  logic [1:0]  axis_block_sigs;
  logic        any_block;
  logic [3:0]  first_ch;
  logic        first_valid;
  logic [31:0] first_time;
  logic        clear;
  logic [3:0]  stat_sel;
  logic [31:0] stat_cycles;

  int checks   = 0;
  int failures = 0;

  axis_stall_detector #(
    .NUM_CH       (2),
    .STALL_CYCLES (4),
    .DIR_MASK     (2'b01),
    .CNT_W        (16)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .enable          (enable),
    .tvalid          (tvalid),
    .tready          (tready),
    .axis_block_sigs (axis_block_sigs),
    .any_block       (any_block),
    .first_ch        (first_ch),
    .first_valid     (first_valid),
    .first_time      (first_time),
    .clear           (clear),
    .stat_sel        (stat_sel),
    .stat_cycles     (stat_cycles)
  );

  // Clock and reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Driver: advance one edge, then settle away from it
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset    = 1'b0;
    enable   = 1'b1;
    clear    = 1'b0;
    tvalid   = 2'b00;
    tready   = 2'b00;
    stat_sel = 4'd0;
    #2;
    check("rst_block", 32'(axis_block_sigs), 32'd0);
    check("rst_any", 32'(any_block), 32'd0);
    check("rst_fvalid", 32'(first_valid), 32'd0);
    check("rst_fch", 32'(first_ch), 32'd0);
    check("rst_ftime", first_time, 32'd0);
    check("rst_stat", stat_cycles, 32'd0);
    #20 reset = 1'b1;

    // cycles 0-9: patterns that are not waits for each channel's direction
    tvalid = 2'b01;
    tready = 2'b10;
    repeat (10) tick();
    check("dir_nowait_block", 32'(axis_block_sigs), 32'd0);
    check("dir_nowait_cnt0", 32'(dut.cnt_q[0]), 32'd0);
    check("dir_nowait_cnt1", 32'(dut.cnt_q[1]), 32'd0);

    // cycles 10-13: ch0 starved
    tvalid = 2'b00;
    tready = 2'b01;
    repeat (3) tick();
    check("starve_pre", 32'(axis_block_sigs), 32'd0);
    tick();
    check("starve_block", 32'(axis_block_sigs), 32'd1);
    check("starve_any", 32'(any_block), 32'd1);
    check("starve_fvalid", 32'(first_valid), 32'd1);
    check("starve_fch", 32'(first_ch), 32'd0);
    check("starve_ftime", first_time, 32'd13);

    // cycle 14: handshake on ch0 releases it
    tvalid = 2'b01;
    tready = 2'b01;
    tick();
    check("release_block", 32'(axis_block_sigs), 32'd0);
    check("release_any", 32'(any_block), 32'd0);
    check("release_fvalid", 32'(first_valid), 32'd1);
    check("release_ftime", first_time, 32'd13);

    // cycles 15-17: ch1 backpressured, cycle 18 handshake
    tvalid = 2'b10;
    tready = 2'b00;
    repeat (3) tick();
    check("bp_block", 32'(axis_block_sigs), 32'd0);
    check("bp_cnt", 32'(dut.cnt_q[1]), 32'd3);
    tready = 2'b10;
    tick();
    check("bp_hs_block", 32'(axis_block_sigs), 32'd0);
    check("bp_hs_cnt", 32'(dut.cnt_q[1]), 32'd0);

    // cycle 19: clear the capture
    tvalid = 2'b00;
    tready = 2'b00;
    clear  = 1'b1;
    tick();
    clear = 1'b0;
    check("clr_fvalid", 32'(first_valid), 32'd0);
    check("clr_ftime", first_time, 32'd0);

    // cycles 20-23: both channels stall together
    tvalid = 2'b10;
    tready = 2'b01;
    repeat (3) tick();
    check("sim_pre", 32'(axis_block_sigs), 32'd0);
    tick();
    check("sim_block", 32'(axis_block_sigs), 32'd3);
    check("sim_any", 32'(any_block), 32'd1);
    check("sim_fch", 32'(first_ch), 32'd0);
    check("sim_ftime", first_time, 32'd23);

    // cycle 24: clear wins over continuing waits
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr2_block", 32'(axis_block_sigs), 32'd0);
    check("clr2_any", 32'(any_block), 32'd0);
    check("clr2_fvalid", 32'(first_valid), 32'd0);
    check("clr2_ftime", first_time, 32'd0);
    repeat (3) tick();
    check("reblock_pre", 32'(axis_block_sigs), 32'd0);
    tick();
    check("reblock_block", 32'(axis_block_sigs), 32'd3);
    check("reblock_ftime", first_time, 32'd28);

    // cycle 29: enable low drops flags but keeps the capture
    enable = 1'b0;
    tick();
    enable = 1'b1;
    check("en_block", 32'(axis_block_sigs), 32'd0);
    check("en_fvalid", 32'(first_valid), 32'd1);
    check("en_ftime", first_time, 32'd28);
    repeat (4) tick();
    check("en_reblock", 32'(axis_block_sigs), 32'd3);

    // asynchronous reset between edges
    reset = 1'b0;
    #2;
    check("arst_block", 32'(axis_block_sigs), 32'd0);
    check("arst_any", 32'(any_block), 32'd0);
    check("arst_fvalid", 32'(first_valid), 32'd0);
    check("arst_ftime", first_time, 32'd0);
    #1 reset = 1'b1;
    repeat (3) tick();
    check("arst_pre", 32'(axis_block_sigs), 32'd0);
    tick();
    check("arst_block2", 32'(axis_block_sigs), 32'd3);
    check("arst_ftime2", first_time, 32'd3);

    // cycle 4 clear, then ch1 alone blocks at cycle 8 and stays for 10 cycles
    tvalid = 2'b10;
    tready = 2'b00;
    clear  = 1'b1;
    tick();
    clear = 1'b0;
    repeat (4) tick();
    check("st_block", 32'(axis_block_sigs), 32'd2);
    check("st_fch", 32'(first_ch), 32'd1);
    check("st_ftime", first_time, 32'd8);
    repeat (9) tick();
    tvalid = 2'b00;
    tick();
    check("st_release", 32'(axis_block_sigs), 32'd0);
    stat_sel = 4'd1;
    tick();
    check("stat_ch1", stat_cycles, EXP_STAT);
    stat_sel = 4'd5;
    tick();
    check("stat_oob", stat_cycles, 32'd0);
    stat_sel = 4'd0;
    tick();
    check("stat_ch0", stat_cycles, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
